mandala_frame_ctrl: RTL and testbench

Per-frame animation and parameter controller that sits directly upstream of the mandala pixel generator. All state is clocked on the single pixel clock. The block detects the frame boundary from the sync generator's vsync and updates its state only at that boundary: pattern/colour counters, the fixed/random mode, and eight ring radii held in shadow registers. The pixel stage consumes these outputs combinationally and sees a tear-free parameter set for the whole frame. Two debounced push-buttons add pause and manual mode toggle.

---
 rtl/mandala_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mandala_frame_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mandala_frame_ctrl.sv
// rtl/mandala_frame_ctrl.sv - per-frame animation/parameter controller for the mandala pixel generator
// All animation state moves only on the vsync-derived frame tick so the pixel stage sees a stable set per frame.
module mandala_frame_ctrl #(
    parameter int          SWITCH_FRAMES   = 120,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          BASE_STEP       = 20000,
    parameter int          DEBOUNCE_FRAMES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vsync,
    input  logic         pause_btn,
    input  logic         mode_btn,
    output logic         frame_tick,
    output logic         mode_select,
    output logic         paused,
    output logic [9:0]   pattern_count,
    output logic [7:0]   color_count,
    output logic [159:0] radii
);

    localparam int             FC_W    = (SWITCH_FRAMES > 2) ? $clog2(SWITCH_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(SWITCH_FRAMES - 1);
    localparam logic [2:0]     DB_LAST = 3'(DEBOUNCE_FRAMES - 1);
    localparam logic [19:0]    STEP    = 20'(BASE_STEP);

    function automatic logic [159:0] fixed_set();
        logic [159:0] r;
        logic [19:0]  acc;
        r   = '0;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc           = acc + STEP;
            r[k*20 +: 20] = acc;
        end
        return r;
    endfunction

    localparam logic [159:0] FIXED_RADII = fixed_set();

    logic               vsync_d_q;
    logic               frame_tick_q, frame_tick_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [1:0]         pause_sync_q, mode_sync_q;
    logic [2:0]         pause_cnt_q, pause_cnt_d;
    logic [2:0]         mode_cnt_q, mode_cnt_d;
    logic               pause_acc_q, pause_acc_d;
    logic               mode_acc_q, mode_acc_d;
    logic               pause_press, mode_press;
    logic               paused_q, paused_d;
    logic               mode_q, mode_d;
    logic [9:0]         pattern_q, pattern_d;
    logic [7:0]         color_q, color_d;
    logic [FC_W-1:0]    fc_q, fc_d;
    logic [159:0]       radii_q, radii_d;
    logic [159:0]       rand_radii;
    logic [7:0]         slice [8];
    logic [19:0]        rand_acc;

    always_comb begin
        frame_tick_d = vsync & ~vsync_d_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    end

    // A button level is accepted only after DEBOUNCE_FRAMES consecutive differing ticks.
    always_comb begin
        pause_cnt_d = pause_cnt_q;
        pause_acc_d = pause_acc_q;
        pause_press = 1'b0;
        if (frame_tick_q) begin
            if (pause_sync_q[1] == pause_acc_q) begin
                pause_cnt_d = '0;
            end else if (pause_cnt_q == DB_LAST) begin
                pause_cnt_d = '0;
                pause_acc_d = pause_sync_q[1];
                pause_press = pause_sync_q[1];
            end else begin
                pause_cnt_d = pause_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        mode_cnt_d = mode_cnt_q;
        mode_acc_d = mode_acc_q;
        mode_press = 1'b0;
        if (frame_tick_q) begin
            if (mode_sync_q[1] == mode_acc_q) begin
                mode_cnt_d = '0;
            end else if (mode_cnt_q == DB_LAST) begin
                mode_cnt_d = '0;
                mode_acc_d = mode_sync_q[1];
                mode_press = mode_sync_q[1];
            end else begin
                mode_cnt_d = mode_cnt_q + 3'd1;
            end
        end
    end

    // Random ring set: cumulative sums keep r1..r8 strictly increasing.
    always_comb begin
        slice[0]   = lfsr_q[7:0];
        slice[1]   = lfsr_q[15:8];
        slice[2]   = lfsr_q[11:4];
        slice[3]   = lfsr_q[14:7];
        slice[4]   = lfsr_q[10:3];
        slice[5]   = lfsr_q[13:6];
        slice[6]   = lfsr_q[9:2];
        slice[7]   = lfsr_q[12:5];
        rand_acc   = '0;
        rand_radii = '0;
        for (int k = 0; k < 8; k++) begin
            rand_acc               = rand_acc + STEP + {4'b0, slice[k], 8'b0};
            rand_radii[k*20 +: 20] = rand_acc;
        end
    end

    always_comb begin
        paused_d  = paused_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        color_d   = color_q;
        fc_d      = fc_q;
        radii_d   = radii_q;
        if (frame_tick_q) begin
            if (pause_press) begin
                paused_d = ~paused_q;
            end
            if (mode_press) begin
                mode_d = ~mode_q;
                fc_d   = '0;
            end
            if (!paused_d) begin
                pattern_d = pattern_q + 10'd1;
                color_d   = color_q + 8'd1;
                // A manual toggle on this tick owns the mode; skip the automatic switch.
                if (!mode_press) begin
                    if (fc_q == FC_LAST) begin
                        fc_d   = '0;
                        mode_d = ~mode_q;
                    end else begin
                        fc_d = fc_q + FC_W'(1);
                    end
                end
            end
            if (!paused_d || mode_press) begin
                radii_d = mode_d ? rand_radii : FIXED_RADII;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_q    <= 1'b1;
            frame_tick_q <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            pause_sync_q <= '0;
            mode_sync_q  <= '0;
            pause_cnt_q  <= '0;
            mode_cnt_q   <= '0;
            pause_acc_q  <= 1'b0;
            mode_acc_q   <= 1'b0;
            paused_q     <= 1'b0;
            mode_q       <= 1'b0;
            pattern_q    <= '0;
            color_q      <= '0;
            fc_q         <= '0;
            radii_q      <= FIXED_RADII;
        end else begin
            vsync_d_q    <= vsync;
            frame_tick_q <= frame_tick_d;
            lfsr_q       <= lfsr_d;
            pause_sync_q <= {pause_sync_q[0], pause_btn};
            mode_sync_q  <= {mode_sync_q[0], mode_btn};
            pause_cnt_q  <= pause_cnt_d;
            mode_cnt_q   <= mode_cnt_d;
            pause_acc_q  <= pause_acc_d;
            mode_acc_q   <= mode_acc_d;
            paused_q     <= paused_d;
            mode_q       <= mode_d;
            pattern_q    <= pattern_d;
            color_q      <= color_d;
            fc_q         <= fc_d;
            radii_q      <= radii_d;
        end
    end

    assign frame_tick    = frame_tick_q;
    assign mode_select   = mode_q;
    assign paused        = paused_q;
    assign pattern_count = pattern_q;
    assign color_count   = color_q;
    assign radii         = radii_q;

endmodule

// File: tb/tb_mandala_frame_ctrl.sv
// tb/tb_mandala_frame_ctrl.sv - directed self-checking bench for mandala_frame_ctrl
module tb_mandala_frame_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vsync;
    logic         pause_btn;
    logic         mode_btn;
    logic         frame_tick;
    logic         mode_select;
    logic         paused;
    logic [9:0]   pattern_count;
    logic [7:0]   color_count;
    logic [159:0] radii;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           tick_cnt = 0;
    logic [15:0]  lfsr_m;
    logic [15:0]  lf;
    logic [159:0] exp_radii;

    mandala_frame_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vsync         (vsync),
        .pause_btn     (pause_btn),
        .mode_btn      (mode_btn),
        .frame_tick    (frame_tick),
        .mode_select   (mode_select),
        .paused        (paused),
        .pattern_count (pattern_count),
        .color_count   (color_count),
        .radii         (radii)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[14] ^ lfsr_m[12] ^ lfsr_m[3]};
    end

    always @(posedge clk) begin
        if (frame_tick === 1'b1) tick_cnt++;
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [159:0] fixed_model();
        logic [159:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*20 +: 20] = 20'((k + 1) * 20000);
        return r;
    endfunction

    function automatic logic [159:0] rand_model(input logic [15:0] l);
        logic [159:0] r;
        logic [19:0]  acc;
        logic [7:0]   s [8];
        s[0] = l[7:0];  s[1] = l[15:8]; s[2] = l[11:4]; s[3] = l[14:7];
        s[4] = l[10:3]; s[5] = l[13:6]; s[6] = l[9:2];  s[7] = l[12:5];
        r   = '0;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = acc + 20'd20000 + {4'd0, s[k], 8'd0};
            r[k*20 +: 20] = acc;
        end
        return r;
    endfunction

    function automatic logic increasing(input logic [159:0] r);
        for (int k = 1; k < 8; k++)
            if (r[k*20 +: 20] <= r[(k-1)*20 +: 20]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_frame(output logic [15:0] lf_tick);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        check("tick_hi", frame_tick, 1);
        lf_tick = lfsr_m;
        @(negedge clk);
        check("tick_lo", frame_tick, 0);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        logic [15:0] dummy;
        for (int i = 0; i < n; i++) do_frame(dummy);
    endtask

    task automatic check_counts(input string tag, input int pat, input int col);
        check({tag, "_pattern"}, pattern_count, 160'(pat));
        check({tag, "_color"}, color_count, 160'(col));
    endtask

    initial begin
        rst_n     = 1'b0;
        vsync     = 1'b1;
        pause_btn = 1'b0;
        mode_btn  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (4) @(negedge clk);
        check("no_tick_vsync_high", tick_cnt, 0);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        check("no_tick_after_fall", tick_cnt, 0);
        check("rst_mode", mode_select, 0);
        check("rst_paused", paused, 0);
        check_counts("rst", 0, 0);
        check("rst_radii", radii, fixed_model());

        frames(5);
        check("five_ticks", tick_cnt, 5);
        check_counts("five", 5, 5);

        frames(114);
        check("mode_before_120", mode_select, 0);
        do_frame(lf);
        check("mode_at_120", mode_select, 1);
        check("radii_at_120", radii, rand_model(lf));
        check("radii_inc_120", increasing(radii), 1);
        check_counts("t120", 120, 120);
        do_frame(lf);
        check("radii_at_121", radii, rand_model(lf));
        frames(118);
        check("mode_before_240", mode_select, 1);
        do_frame(lf);
        check("mode_at_240", mode_select, 0);
        check("radii_at_240", radii, fixed_model());
        check_counts("t240", 240, 240);

        pause_btn = 1'b1;
        frames(3);
        check("pause_3_ticks", paused, 0);
        check_counts("pause3", 243, 243);
        frames(1);
        check("pause_4th_tick", paused, 1);
        check_counts("pause4", 243, 243);
        pause_btn = 1'b0;
        frames(10);
        check("frozen_paused", paused, 1);
        check_counts("frozen", 243, 243);
        check("frozen_radii", radii, fixed_model());
        pause_btn = 1'b1;
        frames(3);
        check("unpause_3", paused, 1);
        check_counts("unpause3", 243, 243);
        frames(1);
        check("unpause_4", paused, 0);
        check_counts("resume", 244, 244);
        pause_btn = 1'b0;

        frames(112);
        mode_btn = 1'b1;
        frames(3);
        check("mode_pre_press", mode_select, 0);
        check_counts("pre_press", 359, 103);
        do_frame(lf);
        check("mode_press_119", mode_select, 1);
        check("radii_press_119", radii, rand_model(lf));
        check_counts("press119", 360, 104);
        mode_btn = 1'b0;
        frames(119);
        check("fc_cleared_hold", mode_select, 1);
        frames(1);
        check("fc_cleared_switch", mode_select, 0);
        check_counts("t480", 480, 224);

        pause_btn = 1'b1;
        frames(2);
        pause_btn = 1'b0;
        frames(2);
        check("short_pulse", paused, 0);
        check_counts("short", 484, 228);
        pause_btn = 1'b1;
        frames(3);
        pause_btn = 1'b0;
        frames(1);
        pause_btn = 1'b1;
        frames(3);
        check("bounce_restart", paused, 0);
        frames(1);
        check("bounce_accept", paused, 1);
        check_counts("bounce", 491, 235);

        mode_btn = 1'b1;
        frames(3);
        check("pmode_pre", mode_select, 0);
        do_frame(lf);
        exp_radii = rand_model(lf);
        check("pmode_toggle", mode_select, 1);
        check("pmode_radii", radii, exp_radii);
        check_counts("pmode", 491, 235);
        frames(1);
        check("pmode_radii_frozen", radii, exp_radii);
        check("pmode_still_paused", paused, 1);

        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tick", frame_tick, 0);
        check("mid_rst_mode", mode_select, 0);
        check("mid_rst_paused", paused, 0);
        check_counts("mid_rst", 0, 0);
        check("mid_rst_radii", radii, fixed_model());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
